// File: rtl/icarus_pkg.sv
// Shared types and sizes for the Icarus job controller.
package icarus_pkg;

  localparam int JOB_BYTES      = 44;
  localparam int MIDSTATE_BYTES = 32;
  localparam int NONCE_BYTES    = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_MINING    = 3'd3,
    ST_SEND      = 3'd4
  } state_e;

endpackage

// File: rtl/job_rx_assembler.sv
// Collects a 44-byte work packet from the host byte stream into shadow
// registers and publishes midstate/data2 atomically when the packet completes.
module job_rx_assembler
  import icarus_pkg::*;
#(
  parameter int RX_GAP_TIMEOUT = 100000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         job_done
);

  localparam int GAP_W = $clog2(RX_GAP_TIMEOUT + 1);

  logic [5:0]       count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [255:0]     shadow_mid_q, shadow_mid_d;
  logic [95:0]      shadow_d2_q, shadow_d2_d;
  logic [255:0]     midstate_q, midstate_d;
  logic [95:0]      data2_q, data2_d;
  logic [3:0]       d2_idx;

  always_comb begin
    count_d      = count_q;
    gap_d        = gap_q;
    shadow_mid_d = shadow_mid_q;
    shadow_d2_d  = shadow_d2_q;
    midstate_d   = midstate_q;
    data2_d      = data2_q;
    job_done     = 1'b0;
    d2_idx       = 4'(count_q - 6'(MIDSTATE_BYTES));
    if (rx_valid) begin
      gap_d = '0;
      if (count_q < 6'(MIDSTATE_BYTES)) begin
        shadow_mid_d[{count_q[4:0], 3'b000} +: 8] = rx_data;
      end else begin
        shadow_d2_d[{d2_idx, 3'b000} +: 8] = rx_data;
      end
      // The last byte is always a data2 byte, so merge it on the way out.
      if (count_q == 6'(JOB_BYTES - 1)) begin
        count_d    = '0;
        job_done   = 1'b1;
        midstate_d = shadow_mid_q;
        data2_d    = shadow_d2_d;
      end else begin
        count_d = count_q + 6'd1;
      end
    end else if (count_q != '0) begin
      if (gap_q == GAP_W'(RX_GAP_TIMEOUT - 1)) begin
        count_d = '0;
        gap_d   = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      gap_q        <= '0;
      shadow_mid_q <= '0;
      shadow_d2_q  <= '0;
      midstate_q   <= '0;
      data2_q      <= '0;
    end else begin
      count_q      <= count_d;
      gap_q        <= gap_d;
      shadow_mid_q <= shadow_mid_d;
      shadow_d2_q  <= shadow_d2_d;
      midstate_q   <= midstate_d;
      data2_q      <= data2_d;
    end
  end

  assign midstate = midstate_q;
  assign data2    = data2_q;

endmodule

// File: rtl/icarus_job_ctrl.sv
// Job controller: hands assembled work to the miner core, supervises it and
// returns the golden nonce to the host one byte at a time.
module icarus_job_ctrl
  import icarus_pkg::*;
#(
  parameter int          START_LEN      = 4,
  parameter int          BUSY_TIMEOUT   = 16,
  parameter int          RX_GAP_TIMEOUT = 100000,
  parameter logic [31:0] NONCE_OFFSET   = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [7:0]   tx_data,
  output logic [255:0] midstate,
  output logic [95:0]  data2,
  output logic         start_mining,
  input  logic         miner_busy,
  input  logic         got_ticket,
  input  logic [31:0]  golden_nonce,
  output logic         job_active,
  output logic         busy_err,
  output state_e       dbg_state
);

  // TX handshake: a byte moves on every clock edge where tx_valid && tx_ready;
  // tx_valid/tx_data stay stable until then. RX is a strobe with no backpressure.

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        ticket_q, ticket_d;
  logic [31:0] nonce_q, nonce_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        start_mining_q, start_mining_d;
  logic        busy_err_q, busy_err_d;
  logic        job_done;
  logic        tx_fire;
  logic        ticket_rise;

  job_rx_assembler #(
    .RX_GAP_TIMEOUT(RX_GAP_TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .midstate (midstate),
    .data2    (data2),
    .job_done (job_done)
  );

  assign tx_fire     = tx_valid_q && tx_ready;
  assign ticket_rise = got_ticket && !ticket_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      ticket_q       <= 1'b0;
      nonce_q        <= '0;
      tx_idx_q       <= '0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      start_mining_q <= 1'b0;
      busy_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      ticket_q       <= ticket_d;
      nonce_q        <= nonce_d;
      tx_idx_q       <= tx_idx_d;
      tx_valid_q     <= tx_valid_d;
      tx_data_q      <= tx_data_d;
      start_mining_q <= start_mining_d;
      busy_err_q     <= busy_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    pending_d = pending_q;
    // Cleared while starting so a ticket left over from the last job is no edge.
    ticket_d  = (state_q == ST_START) ? 1'b0 : got_ticket;
    nonce_d   = nonce_q;
    tx_idx_d  = tx_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (job_done) state_d = ST_START;
      end
      ST_START: begin
        if (job_done) begin
          cnt_d = '0;
        end else if (cnt_q == 16'(START_LEN - 1)) begin
          state_d = ST_WAIT_BUSY;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_BUSY: begin
        if (job_done) begin
          state_d = ST_START;
        end else if (miner_busy) begin
          state_d = ST_MINING;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_MINING: begin
        if (job_done) begin
          state_d = ST_START;
        end else if (ticket_rise) begin
          state_d  = ST_SEND;
          nonce_d  = golden_nonce - NONCE_OFFSET;
          tx_idx_d = '0;
        end else if (!miner_busy) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (job_done) pending_d = 1'b1;
        if (tx_fire) begin
          if (tx_idx_q == 2'(NONCE_BYTES - 1)) begin
            tx_idx_d  = '0;
            pending_d = 1'b0;
            state_d   = (pending_q || job_done) ? ST_START : ST_IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    start_mining_d = (state_q == ST_START);
    busy_err_d     = (state_q == ST_WAIT_BUSY) && !job_done && !miner_busy &&
                     (cnt_q == 16'(BUSY_TIMEOUT - 1));
    tx_valid_d     = (state_d == ST_SEND);
    tx_data_d      = tx_data_q;
    if (state_d == ST_SEND) tx_data_d = nonce_d[{tx_idx_d, 3'b000} +: 8];
  end

  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign start_mining = start_mining_q;
  assign busy_err     = busy_err_q;
  assign job_active   = (state_q != ST_IDLE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_icarus_job_ctrl.sv
// Self-checking bench for icarus_job_ctrl with a packet/nonce reference model.
module tb_icarus_job_ctrl;
  import icarus_pkg::*;

  localparam int          START_LEN    = 4;
  localparam int          BUSY_TIMEOUT = 16;
  localparam int          RX_GAP       = 200;
  localparam logic [31:0] NONCE_OFFSET = 32'd5;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic [255:0] midstate;
  logic [95:0]  data2;
  logic         start_mining;
  logic         miner_busy;
  logic         got_ticket;
  logic [31:0]  golden_nonce;
  logic         job_active;
  logic         busy_err;
  state_e       dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_pulses = 0;
  int busy_pulses = 0;
  logic start_prev = 1'b0;

  logic [7:0]   pkt [JOB_BYTES];
  logic [255:0] exp_mid;
  logic [95:0]  exp_d2;
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];
  int           got_cyc_q[$];

  icarus_job_ctrl #(
    .START_LEN      (START_LEN),
    .BUSY_TIMEOUT   (BUSY_TIMEOUT),
    .RX_GAP_TIMEOUT (RX_GAP),
    .NONCE_OFFSET   (NONCE_OFFSET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .midstate     (midstate),
    .data2        (data2),
    .start_mining (start_mining),
    .miner_busy   (miner_busy),
    .got_ticket   (got_ticket),
    .golden_nonce (golden_nonce),
    .job_active   (job_active),
    .busy_err     (busy_err),
    .dbg_state    (dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, records TX transfers and pulse counts
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        got_cyc_q.push_back(cyc);
      end
      if (start_mining && !start_prev) start_pulses++;
      if (busy_err) busy_pulses++;
    end
    start_prev = start_mining;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  // Reference model: byte k of a packet lands at byte lane k of midstate||data2
  task automatic gen_packet(input bit seq);
    for (int k = 0; k < JOB_BYTES; k++) pkt[k] = seq ? 8'(k) : 8'($urandom_range(0, 255));
    exp_mid = '0;
    exp_d2  = '0;
    for (int k = MIDSTATE_BYTES - 1; k >= 0; k--) exp_mid = {exp_mid[247:0], pkt[k]};
    for (int k = JOB_BYTES - 1; k >= MIDSTATE_BYTES; k--) exp_d2 = {exp_d2[87:0], pkt[k]};
  endtask

  task automatic send_packet();
    for (int k = 0; k < JOB_BYTES; k++) send_byte(pkt[k]);
  endtask

  task automatic expect_nonce(input logic [31:0] g);
    logic [31:0] n;
    n = g - NONCE_OFFSET;
    for (int i = 0; i < NONCE_BYTES; i++) exp_q.push_back(n[8*i +: 8]);
  endtask

  task automatic clear_tx();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, input bit rand_ready);
    for (int i = 0; i < budget; i++) begin
      if (got_q.size() >= n) break;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
      tick();
    end
    tx_ready = 1'b1;
  endtask

  task automatic run_to_mining(input bit seq);
    gen_packet(seq);
    send_packet();
    repeat (2) tick();
    miner_busy = 1'b1;
    repeat (5) tick();
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    miner_busy = 1'b0; got_ticket = 1'b0; golden_nonce = '0;
    repeat (3) tick();
    checks++; if (midstate !== '0) begin errors++; $display("FAIL reset_midstate: got %h expected 0", midstate); end
    checks++; if (data2 !== '0) begin errors++; $display("FAIL reset_data2: got %h expected 0", data2); end
    checks++; if (start_mining !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start_mining); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (job_active !== 1'b0) begin errors++; $display("FAIL reset_job_active: got %b expected 0", job_active); end
    checks++; if (busy_err !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b expected 0", busy_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_assembly_start();
    int hi;
    int p0;
    hi = 0;
    p0 = start_pulses;
    gen_packet(1'b1);
    send_packet();
    checks++; if (midstate[7:0] !== 8'h00) begin errors++; $display("FAIL asm_mid_lo: got %h expected 00", midstate[7:0]); end
    checks++; if (midstate[255:248] !== 8'h1F) begin errors++; $display("FAIL asm_mid_hi: got %h expected 1f", midstate[255:248]); end
    checks++; if (data2[95:88] !== 8'h2B) begin errors++; $display("FAIL asm_d2_hi: got %h expected 2b", data2[95:88]); end
    checks++; if (midstate !== exp_mid) begin errors++; $display("FAIL asm_mid: got %h expected %h", midstate, exp_mid); end
    checks++; if (data2 !== exp_d2) begin errors++; $display("FAIL asm_d2: got %h expected %h", data2, exp_d2); end
    checks++; if (dbg_state !== ST_START || start_mining !== 1'b0) begin
      errors++; $display("FAIL asm_start_entry: got state %0d start %b expected state %0d start 0", dbg_state, start_mining, ST_START);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (start_mining) hi++;
      if (i == 2) miner_busy = 1'b1;
    end
    checks++; if (hi != START_LEN) begin errors++; $display("FAIL start_len: got %0d expected %0d", hi, START_LEN); end
    checks++; if (start_pulses - p0 != 1) begin errors++; $display("FAIL start_pulses: got %0d expected 1", start_pulses - p0); end
    checks++; if (dbg_state !== ST_MINING || job_active !== 1'b1) begin
      errors++; $display("FAIL reach_mining: got state %0d active %b expected %0d 1", dbg_state, job_active, ST_MINING);
    end
  endtask

  task automatic test_ticket();
    logic [7:0] e;
    clear_tx();
    golden_nonce = 32'h1234_567D;
    expect_nonce(golden_nonce);
    tx_ready   = 1'b1;
    got_ticket = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      errors++; $display("FAIL ticket_first: got valid %b data %h expected 1 %h", tx_valid, tx_data, exp_q[0]);
    end
    wait_bytes(4, 20, 1'b0);
    tick();
    checks++; if (got_cyc_q.size() != 4 || got_cyc_q[3] - got_cyc_q[0] != 3) begin
      errors++; $display("FAIL ticket_consecutive: got %0d bytes expected 4 in 4 cycles", got_cyc_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL ticket_byte: got none expected %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL ticket_byte: got %h expected %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL ticket_idle: got %0d expected %0d", dbg_state, ST_IDLE); end
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    tick();
  endtask

  task automatic test_offset_wrap();
    logic [7:0] e;
    clear_tx();
    run_to_mining(1'b0);
    golden_nonce = 32'h0000_0002;
    expect_nonce(golden_nonce);
    got_ticket = 1'b1;
    wait_bytes(4, 20, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL wrap_byte: got none expected %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL wrap_byte: got %h expected %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gap_drop();
    logic [255:0] old_mid;
    int p0;
    old_mid = midstate;
    p0 = start_pulses;
    for (int k = 0; k < 20; k++) send_byte(8'($urandom_range(0, 255)));
    repeat (RX_GAP + 5) tick();
    checks++; if (dbg_state !== ST_IDLE || midstate !== old_mid) begin
      errors++; $display("FAIL gap_partial: got state %0d expected %0d, outputs must be untouched", dbg_state, ST_IDLE);
    end
    gen_packet(1'b0);
    send_packet();
    checks++; if (midstate !== exp_mid) begin errors++; $display("FAIL gap_mid: got %h expected %h", midstate, exp_mid); end
    checks++; if (data2 !== exp_d2) begin errors++; $display("FAIL gap_d2: got %h expected %h", data2, exp_d2); end
    repeat (30) tick();
    checks++; if (start_pulses - p0 != 1) begin errors++; $display("FAIL gap_starts: got %0d expected 1", start_pulses - p0); end
  endtask

  task automatic test_busy_timeout();
    int first;
    int b0;
    clear_tx();
    first = -1;
    b0 = busy_pulses;
    gen_packet(1'b0);
    send_packet();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (busy_err && first < 0) first = i;
    end
    checks++; if (first != START_LEN + BUSY_TIMEOUT) begin
      errors++; $display("FAIL busy_err_time: got %0d expected %0d", first, START_LEN + BUSY_TIMEOUT);
    end
    checks++; if (busy_pulses - b0 != 1) begin errors++; $display("FAIL busy_err_count: got %0d expected 1", busy_pulses - b0); end
    checks++; if (dbg_state !== ST_IDLE || got_q.size() != 0) begin
      errors++; $display("FAIL busy_idle: got state %0d tx %0d expected %0d 0", dbg_state, got_q.size(), ST_IDLE);
    end
  endtask

  task automatic test_pending();
    logic [7:0] e;
    int p0;
    clear_tx();
    run_to_mining(1'b0);
    golden_nonce = $urandom;
    expect_nonce(golden_nonce);
    tx_ready   = 1'b0;
    got_ticket = 1'b1;
    repeat (3) tick();
    checks++; if (dbg_state !== ST_SEND || tx_valid !== 1'b1 || tx_data !== exp_q[0]) begin
      errors++; $display("FAIL pend_stall: got state %0d valid %b data %h expected %0d 1 %h", dbg_state, tx_valid, tx_data, ST_SEND, exp_q[0]);
    end
    got_ticket = 1'b0;
    miner_busy = 1'b0;
    p0 = start_pulses;
    gen_packet(1'b0);
    send_packet();
    checks++; if (midstate !== exp_mid || data2 !== exp_d2) begin
      errors++; $display("FAIL pend_outputs: got %h expected %h", midstate, exp_mid);
    end
    checks++; if (dbg_state !== ST_SEND || start_pulses != p0) begin
      errors++; $display("FAIL pend_no_abort: got state %0d starts %0d expected %0d 0", dbg_state, start_pulses - p0, ST_SEND);
    end
    wait_bytes(4, 80, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL pend_byte: got none expected %h", e); end
      else if (got_q[0] !== e) begin errors++; $display("FAIL pend_byte: got %h expected %h", got_q.pop_front(), e); end
      else void'(got_q.pop_front());
    end
    repeat (3) tick();
    checks++; if (start_pulses - p0 != 1) begin errors++; $display("FAIL pend_restart: got %0d expected 1", start_pulses - p0); end
    repeat (25) tick();
  endtask

  task automatic test_abort_in_mining();
    int p0;
    clear_tx();
    run_to_mining(1'b0);
    p0 = start_pulses;
    gen_packet(1'b0);
    for (int k = 0; k < JOB_BYTES - 1; k++) send_byte(pkt[k]);
    golden_nonce = $urandom;
    got_ticket   = 1'b1;
    send_byte(pkt[JOB_BYTES-1]);
    checks++; if (dbg_state !== ST_START || midstate !== exp_mid) begin
      errors++; $display("FAIL abort_start: got state %0d expected %0d", dbg_state, ST_START);
    end
    miner_busy = 1'b0;
    repeat (30) tick();
    got_ticket = 1'b0;
    checks++; if (got_q.size() != 0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL abort_ticket_dropped: got tx %0d state %0d expected 0 %0d", got_q.size(), dbg_state, ST_IDLE);
    end
    checks++; if (start_pulses - p0 != 1) begin errors++; $display("FAIL abort_starts: got %0d expected 1", start_pulses - p0); end
  endtask

  task automatic test_random_jobs();
    logic [7:0] e;
    for (int j = 0; j < 4; j++) begin
      clear_tx();
      run_to_mining(1'b0);
      checks++; if (midstate !== exp_mid || data2 !== exp_d2) begin
        errors++; $display("FAIL rand_job_out: got %h expected %h", data2, exp_d2);
      end
      golden_nonce = $urandom;
      expect_nonce(golden_nonce);
      tx_ready   = 1'($urandom_range(0, 1));
      got_ticket = 1'b1;
      wait_bytes(4, 80, 1'b1);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (got_q.size() == 0) begin errors++; $display("FAIL rand_byte: got none expected %h", e); end
        else if (got_q[0] !== e) begin errors++; $display("FAIL rand_byte: got %h expected %h", got_q.pop_front(), e); end
        else void'(got_q.pop_front());
      end
      got_ticket = 1'b0;
      miner_busy = 1'b0;
      repeat ($urandom_range(2, 6)) tick();
    end
  endtask

  task automatic test_reset_midop();
    int p0;
    p0 = start_pulses;
    for (int k = 0; k < 20; k++) send_byte(8'($urandom_range(0, 255)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < JOB_BYTES - 20; k++) send_byte(8'($urandom_range(0, 255)));
    repeat (3) tick();
    checks++; if (dbg_state !== ST_IDLE || start_pulses != p0 || midstate !== '0) begin
      errors++; $display("FAIL reset_midop: got state %0d starts %0d expected %0d 0", dbg_state, start_pulses - p0, ST_IDLE);
    end
  endtask

  initial begin
    test_reset();
    test_assembly_start();
    test_ticket();
    test_offset_wrap();
    test_gap_drop();
    test_busy_timeout();
    test_pending();
    test_abort_in_mining();
    test_random_jobs();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
